// File: rtl/temp_buffer_mc.sv
// temp_buffer_mc: multi-lane row/column temporary buffer.
// Every lane has one row FIFO and one column FIFO. All lanes run from a
// single shared controller, so pointers, counts and flags are common to all
// lanes. Only the stored data differs from lane to lane.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   clean                 clear pointers/counts of both FIFOs
//   stride                entries popped per read (0 acts as 1)
//   wr_r/rd_r, wr_c/rd_c  write mode (NO_WR/WR_DATA/WR_BUF/WR_XFER) and read
//   data_wr               per-lane write data, lane k at [k*DATA_W +: DATA_W]
//   data_out, data_valid  registered head entry of the last successful read
//   row_/col_count        occupancy, plus full/empty flags
//   overflow, underflow   sticky error flags; cmd_err is a one-cycle pulse

// Per-lane storage: both FIFO arrays and the output register.
module temp_buffer_mc_lane #(
   parameter int DATA_W    = 16,
   parameter int ROW_DEPTH = 16,
   parameter int COL_DEPTH = 8,
   localparam int RAW = $clog2(ROW_DEPTH),
   localparam int CAW = $clog2(COL_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] wdat,
   input  logic              row_we,
   input  logic [1:0]        row_src,
   input  logic [RAW-1:0]    row_waddr,
   input  logic [RAW-1:0]    row_raddr,
   input  logic              col_we,
   input  logic [1:0]        col_src,
   input  logic [CAW-1:0]    col_waddr,
   input  logic [CAW-1:0]    col_raddr,
   input  logic              ld_out,
   input  logic              out_col,
   output logic [DATA_W-1:0] dout
);
   logic [DATA_W-1:0] row_mem [ROW_DEPTH];
   logic [DATA_W-1:0] col_mem [COL_DEPTH];
   logic [DATA_W-1:0] row_head, col_head, row_wd, col_wd, dout_q;

   assign row_head = row_mem[row_raddr];
   assign col_head = col_mem[col_raddr];

   // src: 01 external data, 10 own head (recirculate), 11 other FIFO's head
   always_comb begin
      row_wd = wdat;
      col_wd = wdat;
      case (row_src)
         2'b10:   row_wd = row_head;
         2'b11:   row_wd = col_head;
         default: row_wd = wdat;
      endcase
      case (col_src)
         2'b10:   col_wd = col_head;
         2'b11:   col_wd = row_head;
         default: col_wd = wdat;
      endcase
   end

   // The heads are read combinationally before this edge's write, which makes
   // a read and a write on a full FIFO (where rd_ptr == wr_ptr) safe.
   always_ff @(posedge clk) begin
      if (row_we) row_mem[row_waddr] <= row_wd;
      if (col_we) col_mem[col_waddr] <= col_wd;
   end

   always_ff @(posedge clk) begin
      if (reset)       dout_q <= '0;
      else if (ld_out) dout_q <= out_col ? col_head : row_head;
   end

   assign dout = dout_q;
endmodule

module temp_buffer_mc #(
   parameter int DATA_W     = 16,
   parameter int NUM_CH     = 4,
   parameter int ROW_DEPTH  = 16,
   parameter int COL_DEPTH  = 8,
   parameter int MAX_STRIDE = 4,
   localparam int RAW = $clog2(ROW_DEPTH),
   localparam int CAW = $clog2(COL_DEPTH),
   localparam int RCW = $clog2(ROW_DEPTH+1),
   localparam int CCW = $clog2(COL_DEPTH+1),
   localparam int SW  = $clog2(MAX_STRIDE+1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clean,
   input  logic [SW-1:0]            stride,
   input  logic [1:0]               wr_r,
   input  logic                     rd_r,
   input  logic [1:0]               wr_c,
   input  logic                     rd_c,
   input  logic [NUM_CH*DATA_W-1:0] data_wr,
   output logic [NUM_CH*DATA_W-1:0] data_out,
   output logic                     data_valid,
   output logic [RCW-1:0]           row_count,
   output logic [CCW-1:0]           col_count,
   output logic                     row_full,
   output logic                     row_empty,
   output logic                     col_full,
   output logic                     col_empty,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     cmd_err
);
   localparam logic [1:0] WR_DATA = 2'b01, WR_BUF = 2'b10, WR_XFER = 2'b11;

   logic [RAW-1:0] row_rd_q, row_rd_d, row_wr_q, row_wr_d;
   logic [CAW-1:0] col_rd_q, col_rd_d, col_wr_q, col_wr_d;
   logic [RCW-1:0] row_cnt_q, row_cnt_d, row_pop;
   logic [CCW-1:0] col_cnt_q, col_cnt_d, col_pop;
   logic           vld_q, ovf_q, unf_q, err_q;
   logic           illegal, act, row_rd_ok, col_rd_ok;
   logic           row_src_ok, col_src_ok, row_space, col_space;
   logic           row_push, col_push, drop, under;
   logic [31:0]    str_eff;

   logic [NUM_CH-1:0][DATA_W-1:0] lane_wd, lane_dout;

   assign illegal = (rd_r & rd_c)
                  | (wr_r == WR_BUF  & ~rd_r) | (wr_r == WR_XFER & ~rd_c)
                  | (wr_c == WR_BUF  & ~rd_c) | (wr_c == WR_XFER & ~rd_r);
   assign act     = ~clean & ~illegal;

   assign str_eff   = (stride == '0) ? 32'd1 : 32'(stride);
   assign row_rd_ok = act & rd_r & (row_cnt_q != '0);
   assign col_rd_ok = act & rd_c & (col_cnt_q != '0);
   assign row_pop   = ~row_rd_ok ? '0 :
                      (str_eff < 32'(row_cnt_q)) ? RCW'(str_eff) : row_cnt_q;
   assign col_pop   = ~col_rd_ok ? '0 :
                      (str_eff < 32'(col_cnt_q)) ? CCW'(str_eff) : col_cnt_q;

   // A buffer/transfer write only has data when its source read succeeds.
   assign row_src_ok = (wr_r == WR_DATA) | (wr_r == WR_BUF & row_rd_ok)
                     | (wr_r == WR_XFER & col_rd_ok);
   assign col_src_ok = (wr_c == WR_DATA) | (wr_c == WR_BUF & col_rd_ok)
                     | (wr_c == WR_XFER & row_rd_ok);
   assign row_space  = (row_cnt_q != RCW'(ROW_DEPTH)) | row_rd_ok;
   assign col_space  = (col_cnt_q != CCW'(COL_DEPTH)) | col_rd_ok;
   assign row_push   = act & row_src_ok & row_space;
   assign col_push   = act & col_src_ok & col_space;
   assign drop       = act & ((row_src_ok & ~row_space) | (col_src_ok & ~col_space));
   assign under      = act & ((rd_r & row_cnt_q == '0) | (rd_c & col_cnt_q == '0));

   // A push is only allowed when there is room after the pop, so the count
   // stays within 0..DEPTH. Pointers wrap because the depths are powers of 2.
   always_comb begin
      row_rd_d  = row_rd_q + RAW'(row_pop);
      col_rd_d  = col_rd_q + CAW'(col_pop);
      row_wr_d  = row_wr_q + RAW'(row_push);
      col_wr_d  = col_wr_q + CAW'(col_push);
      row_cnt_d = row_cnt_q - row_pop + RCW'(row_push);
      col_cnt_d = col_cnt_q - col_pop + CCW'(col_push);
      if (clean) begin
         row_rd_d  = '0;
         col_rd_d  = '0;
         row_wr_d  = '0;
         col_wr_d  = '0;
         row_cnt_d = '0;
         col_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_rd_q  <= '0;
         row_wr_q  <= '0;
         col_rd_q  <= '0;
         col_wr_q  <= '0;
         row_cnt_q <= '0;
         col_cnt_q <= '0;
         vld_q     <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         row_rd_q  <= row_rd_d;
         row_wr_q  <= row_wr_d;
         col_rd_q  <= col_rd_d;
         col_wr_q  <= col_wr_d;
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
         vld_q     <= row_rd_ok | col_rd_ok;
         ovf_q     <= ovf_q | drop;
         unf_q     <= unf_q | under;
         err_q     <= ~clean & illegal;
      end
   end

   assign lane_wd = data_wr;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      temp_buffer_mc_lane #(
         .DATA_W(DATA_W), .ROW_DEPTH(ROW_DEPTH), .COL_DEPTH(COL_DEPTH)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .wdat     (lane_wd[k]),
         .row_we   (row_push),
         .row_src  (wr_r),
         .row_waddr(row_wr_q),
         .row_raddr(row_rd_q),
         .col_we   (col_push),
         .col_src  (wr_c),
         .col_waddr(col_wr_q),
         .col_raddr(col_rd_q),
         .ld_out   (row_rd_ok | col_rd_ok),
         .out_col  (col_rd_ok),
         .dout     (lane_dout[k])
      );
   end

   assign data_out   = lane_dout;
   assign data_valid = vld_q;
   assign row_count  = row_cnt_q;
   assign col_count  = col_cnt_q;
   assign row_full   = (row_cnt_q == RCW'(ROW_DEPTH));
   assign row_empty  = (row_cnt_q == '0);
   assign col_full   = (col_cnt_q == CCW'(COL_DEPTH));
   assign col_empty  = (col_cnt_q == '0);
   assign overflow   = ovf_q;
   assign underflow  = unf_q;
   assign cmd_err    = err_q;
endmodule

// File: tb/tb_temp_buffer_mc.sv
module tb_temp_buffer_mc;
   localparam int DW = 16, NC = 4, RD = 16, CD = 8, MS = 4;

   logic              clk = 1'b0;
   logic              reset, clean, rd_r, rd_c;
   logic [2:0]        stride;
   logic [1:0]        wr_r, wr_c;
   logic [NC*DW-1:0]  data_wr, data_out;
   logic              data_valid, row_full, row_empty, col_full, col_empty;
   logic              overflow, underflow, cmd_err;
   logic [4:0]        row_count;
   logic [3:0]        col_count;

   temp_buffer_mc #(.DATA_W(DW), .NUM_CH(NC), .ROW_DEPTH(RD), .COL_DEPTH(CD),
                    .MAX_STRIDE(MS)) dut (
      .clk(clk), .reset(reset), .clean(clean), .stride(stride),
      .wr_r(wr_r), .rd_r(rd_r), .wr_c(wr_c), .rd_c(rd_c), .data_wr(data_wr),
      .data_out(data_out), .data_valid(data_valid),
      .row_count(row_count), .col_count(col_count),
      .row_full(row_full), .row_empty(row_empty),
      .col_full(col_full), .col_empty(col_empty),
      .overflow(overflow), .underflow(underflow), .cmd_err(cmd_err));

   always #5 clk = ~clk;

   // One record per cycle: inputs applied for that cycle, outputs expected
   // just after the following rising edge. Lane k carries d+k; expected
   // data_out lane k is ed+k, or 0 when ed is 0 (reset value).
   typedef struct {
      bit rst, cln; int str; int wr, wc; bit rr, rc; int d;
      int ed; bit ev; int erc, ecc; bit eo, eu, ee;
   } vec_t;
   vec_t vq[$];
   int tests = 0, fails = 0;

   task automatic add(input bit rst, cln, input int str, wr, input bit rr,
                      input int wc, input bit rc, input int d, ed, input bit ev,
                      input int erc, ecc, input bit eo, eu, ee);
      vec_t v;
      v.rst = rst; v.cln = cln; v.str = str; v.wr = wr; v.wc = wc;
      v.rr = rr; v.rc = rc; v.d = d; v.ed = ed; v.ev = ev;
      v.erc = erc; v.ecc = ecc; v.eo = eo; v.eu = eu; v.ee = ee;
      vq.push_back(v);
   endtask

   task automatic chk(input int idx, input string nm, input int got, exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL vec%0d %s: got %0d expected %0d", idx, nm, got, exp);
      end
   endtask

   task automatic rst_vec();
      add(1,0,1,0,0,0,0,0, 0,0,0,0,0,0,0);
   endtask

   initial begin
      // Basic latency / underflow
      rst_vec();
      add(0,0,1,1,0,1,0,972, 0,0,1,1,0,0,0);
      add(0,0,1,0,1,0,0,0, 972,1,0,1,0,0,0);
      add(0,0,1,0,1,0,0,0, 972,0,0,1,0,1,0);
      rst_vec();
      // Order, column full, dropped writes
      for (int i = 1; i <= 7; i++) add(0,0,1,1,0,1,0,i, 0,0,i,i,0,0,0);
      add(0,0,1,0,1,1,0,8,  1,1,6,8,0,0,0);
      add(0,0,1,0,1,1,0,9,  2,1,5,8,1,0,0);
      add(0,0,1,0,1,1,0,10, 3,1,4,8,1,0,0);
      for (int i = 4; i <= 7; i++) add(0,0,1,0,1,0,0,0, i,1,7-i,8,1,0,0);
      // Recirculation then plain drain
      for (int i = 1; i <= 8; i++) add(0,0,1,0,0,2,1,0, i,1,0,8,1,0,0);
      for (int i = 1; i <= 8; i++) add(0,0,1,0,0,0,1,0, i,1,0,8-i,1,0,0);
      rst_vec();
      // Stride 3 over 1..10
      for (int i = 1; i <= 10; i++) add(0,0,1,1,0,0,0,i, 0,0,i,0,0,0,0);
      for (int j = 0; j < 3; j++) add(0,0,3,0,1,0,0,0, 1+3*j,1,7-3*j,0,0,0,0);
      add(0,0,3,0,1,0,0,0, 10,1,0,0,0,0,0);
      // Transfer column -> row, illegal commands, stride 0
      add(0,0,1,0,0,1,0,5, 10,0,0,1,0,0,0);
      add(0,0,1,0,0,1,0,6, 10,0,0,2,0,0,0);
      add(0,0,1,3,0,0,1,0, 5,1,1,1,0,0,0);
      add(0,0,1,3,0,0,1,0, 6,1,2,0,0,0,0);
      add(0,0,1,0,1,0,1,0, 6,0,2,0,0,0,1);
      add(0,0,1,0,0,0,0,0, 6,0,2,0,0,0,0);
      add(0,0,1,2,0,0,0,0, 6,0,2,0,0,0,1);
      add(0,0,1,0,0,0,0,0, 6,0,2,0,0,0,0);
      add(0,0,0,0,1,0,0,0, 5,1,1,0,0,0,0);
      // Clean during a write, then reset with FIFOs half full
      add(0,1,1,1,0,0,0,77, 5,0,0,0,0,0,0);
      for (int i = 1; i <= 4; i++) add(0,0,1,1,0,1,0,i, 5,0,i,i,0,0,0);
      rst_vec();
      // Simultaneous XFER into row and BUF into column
      add(0,0,1,0,0,1,0,21, 0,0,0,1,0,0,0);
      add(0,0,1,0,0,1,0,22, 0,0,0,2,0,0,0);
      add(0,0,1,3,0,2,1,0, 21,1,1,2,0,0,0);
      add(0,0,1,0,0,0,1,0, 22,1,1,1,0,0,0);
      add(0,0,1,0,0,0,1,0, 21,1,1,0,0,0,0);
      add(0,0,1,0,1,0,0,0, 21,1,0,0,0,0,0);
      // Row full: dropped write, then read+write on full, then stride 4
      for (int i = 1; i <= 16; i++) add(0,0,1,1,0,0,0,i, 21,0,i,0,0,0,0);
      add(0,0,1,1,0,0,0,99, 21,0,16,0,1,0,0);
      add(0,0,1,1,1,0,0,50, 1,1,16,0,1,0,0);
      add(0,0,4,0,1,0,0,0, 2,1,12,0,1,0,0);

      @(negedge clk);
      foreach (vq[n]) begin
         reset = vq[n].rst; clean = vq[n].cln; stride = 3'(vq[n].str);
         wr_r = 2'(vq[n].wr); wr_c = 2'(vq[n].wc);
         rd_r = vq[n].rr; rd_c = vq[n].rc;
         for (int k = 0; k < NC; k++) data_wr[k*DW +: DW] = DW'(vq[n].d + k);
         @(negedge clk);
         begin
            int bad = 0;
            for (int k = 0; k < NC; k++) begin
               logic [DW-1:0] e;
               e = (vq[n].ed == 0) ? '0 : DW'(vq[n].ed + k);
               if (data_out[k*DW +: DW] !== e) bad++;
            end
            tests++;
            if (bad != 0) begin
               fails++;
               $display("FAIL vec%0d data_out: got lane0 %0d (%0d lanes wrong) expected lane0 %0d",
                        n, data_out[DW-1:0], bad, vq[n].ed);
            end
         end
         chk(n, "data_valid", int'(data_valid), int'(vq[n].ev));
         chk(n, "row_count", int'(row_count), vq[n].erc);
         chk(n, "col_count", int'(col_count), vq[n].ecc);
         chk(n, "overflow", int'(overflow), int'(vq[n].eo));
         chk(n, "underflow", int'(underflow), int'(vq[n].eu));
         chk(n, "cmd_err", int'(cmd_err), int'(vq[n].ee));
         chk(n, "flags", int'({row_full, row_empty, col_full, col_empty}),
             int'({vq[n].erc == RD, vq[n].erc == 0, vq[n].ecc == CD, vq[n].ecc == 0}));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/temp_buffer_mc.md
Name: temp_buffer_mc

Overview:
Parametrised, multi-channel successor to the CNN temporary buffer. Each of NUM_CH lanes holds a row FIFO and a column FIFO, and all lanes share one command set. Adds configurable depth and width, strided reads, cross-FIFO transfer, status flags and a registered valid output. Sits between the PE array partial-sum path and the convolution window sequencer.

Parameters:
DATA_W, 16, lane data width in bits (signed)
NUM_CH, 4, number of parallel lanes (identical control, independent data)
ROW_DEPTH, 16, row FIFO entries per lane (power of 2, >=2)
COL_DEPTH, 8, column FIFO entries per lane (power of 2, >=2)
MAX_STRIDE, 4, largest supported read stride

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
clean  in  1  clear both FIFOs in all lanes (pointers/counts only)
stride  in  $clog2(MAX_STRIDE+1)  entries popped per read; 0 treated as 1
wr_r  in  2  row FIFO write mode: 00 NO_WR, 01 WR_DATA, 10 WR_BUF, 11 WR_XFER
rd_r  in  1  read row FIFO
wr_c  in  2  column FIFO write mode, same encoding
rd_c  in  1  read column FIFO
data_wr  in  NUM_CH*DATA_W  write data; lane k = bits [k*DATA_W +: DATA_W]
data_out  out  NUM_CH*DATA_W  registered read data, signed per lane
data_valid  out  1  data_out updated by a successful read last cycle
row_count  out  $clog2(ROW_DEPTH+1)  row FIFO occupancy (identical across lanes)
col_count  out  $clog2(COL_DEPTH+1)  column FIFO occupancy
row_full, row_empty, col_full, col_empty  out  1 each  combinational from counts
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read hit an empty FIFO
cmd_err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset: all pointers and counts = 0, data_out = 0, data_valid = 0, overflow = 0, underflow = 0, cmd_err = 0. Reset is synchronous and overrides everything, including mid-operation; FIFO storage contents need not be cleared.
- Priority per cycle: reset > clean > illegal-command check > normal read/write.
- clean: counts and pointers = 0 next cycle, data_valid = 0, data_out holds its value, all reads/writes that cycle ignored, sticky flags unchanged.
- Illegal commands: rd_r & rd_c in the same cycle; WR_BUF without a read of the same FIFO; WR_XFER without a read of the other FIFO. Any illegal command: cmd_err = 1 for one cycle, no FIFO state changes, data_valid = 0.
- Read (rd_x = 1, FIFO non-empty):
  - head entry appears on data_out on the next cycle with data_valid = 1 (1-cycle latency);
  - pops min(stride_eff, count) entries, where stride_eff = max(stride, 1);
  - only the head entry is output.
- Read on empty FIFO: no pop, data_out holds, data_valid = 0, underflow set.
- Write modes, per FIFO:
  - WR_DATA pushes data_wr;
  - WR_BUF pushes that FIFO's own head entry being read this cycle (recirculation);
  - WR_XFER pushes the head entry being read from the other FIFO.
- Read-before-write: a read and a write on the same FIFO in one cycle are both honoured even when full (count += 1 - popped). Write on full without a same-FIFO read is dropped and sets overflow.
- Count: new = old - popped + pushed, saturating 0..DEPTH; pointers wrap modulo DEPTH.
- Both FIFOs may be written in the same cycle. Example: wr_r = WR_XFER with rd_c = 1 and wr_c = WR_BUF moves the column head into the row FIFO and also recirculates it into the column FIFO.
- All lanes share pointers, counts and flags; only data differs per lane.
- Arithmetic: no arithmetic on data; values pass through bit-exact.

Test Plan:
- Basic read latency and underflow: reset, WR_DATA 972 into both FIFOs on all lanes (lane k = 972+k). Then rd_r twice -> cycle+1 data_out lane0 = 972, data_valid = 1; second read: data_valid = 0, underflow = 1, data_out holds 972.
- FIFO order and full: write 1..7 to both FIFOs, then WR_DATA 8..10 to the column FIFO while reading the row FIFO. -> Row reads return 1,2,3,4,5,6,7 in order. With COL_DEPTH = 8, col_full asserts after 8; write of 9 with no read is dropped, overflow = 1, col_count stays 8.
- Recirculation: column holds 1..8, then 8 cycles of rd_c with WR_BUF -> outputs 1..8, col_count stays 8. A further 8 plain rd_c reads again return 1..8.
- Stride: row holds 1..10, stride = 3, three rd_r -> outputs 1,4,7 and row_count = 1. A fourth read returns 10 with row_count = 0.
- Transfer and illegal commands: column holds 5,6, rd_c with wr_r = WR_XFER twice -> row holds 5,6. rd_r & rd_c together -> cmd_err pulse, counts unchanged. WR_BUF without read -> cmd_err.
- Clean and reset mid-stream: clean during a write -> counts = 0 next cycle, write ignored. Reset asserted while FIFOs are half full -> all outputs return to reset values next cycle.
